// File: rtl/quarter_step_driver_if.sv
// Command and status bundle between a spin requester and the
// quarter-turn stepper driver.
interface quarter_step_driver_if #(
   parameter int CNT_W = 8
);
   logic             quarter_spin_started;
   logic             dir;
   logic             abort;
   logic             quarter;
   logic [3:0]       coil;
   logic             coil_en;
   logic             step_pulse;
   logic [CNT_W-1:0] steps_done;
   logic             busy;

   modport master (
      output quarter_spin_started, dir, abort,
      input  quarter, coil, coil_en, step_pulse, steps_done, busy
   );

   modport slave (
      input  quarter_spin_started, dir, abort,
      output quarter, coil, coil_en, step_pulse, steps_done, busy
   );
endinterface

// File: rtl/quarter_step_driver.sv
// Executes one quarter revolution of a 4-wire stepper per request,
// with two-phase-on drive and a single quarter fall per turn.
module quarter_step_driver #(
   parameter int STEP_DIV          = 100000,
   parameter int STEPS_PER_QUARTER = 50,
   parameter int DIV_W             = 17,
   parameter int CNT_W             = 8
) (
   input logic                  clk,
   input logic                  resetb,
   quarter_step_driver_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_phase;
   logic             r_dir;
   logic             r_quarter;
   logic [3:0]       r_coil;
   logic             r_coil_en;
   logic             r_step_pulse;
   logic [CNT_W-1:0] r_steps_done;
   logic             r_busy;

   state_t           w_state_n;
   logic [DIV_W-1:0] w_div_n;
   logic [1:0]       w_phase_n;
   logic             w_dir_n;
   logic             w_quarter_n;
   logic [3:0]       w_coil_n;
   logic             w_coil_en_n;
   logic             w_step_n;
   logic [CNT_W-1:0] w_steps_n;
   logic             w_busy_n;
   logic             w_tc;
   logic [CNT_W-1:0] w_steps_inc;

   assign w_tc        = (r_div == DIV_W'(STEP_DIV - 1));
   assign w_steps_inc = r_steps_done + CNT_W'(1);

   // Next state, next outputs, and the phase-table lookup
   always_comb begin
      w_state_n   = r_state;
      w_div_n     = r_div;
      w_phase_n   = r_phase;
      w_dir_n     = r_dir;
      w_quarter_n = r_quarter;
      w_coil_en_n = r_coil_en;
      w_step_n    = 1'b0;
      w_steps_n   = r_steps_done;
      w_busy_n    = r_busy;
      w_coil_n    = 4'b1100;
      unique case (r_state)
         IDLE: begin
            if (bus.quarter_spin_started && !bus.abort) begin
               w_state_n   = RUN;
               w_dir_n     = bus.dir;
               w_div_n     = '0;
               w_steps_n   = '0;
               w_quarter_n = 1'b1;
               w_coil_en_n = 1'b1;
               w_busy_n    = 1'b1;
            end
         end
         RUN: begin
            if (bus.abort) begin
               w_state_n   = IDLE;
               w_quarter_n = 1'b0;
               w_coil_en_n = 1'b0;
               w_busy_n    = 1'b0;
            end else if (w_tc) begin
               w_div_n   = '0;
               w_phase_n = r_dir ? r_phase + 2'd1
                                 : r_phase - 2'd1;
               w_step_n  = 1'b1;
               w_steps_n = w_steps_inc;
               if (w_steps_inc == CNT_W'(STEPS_PER_QUARTER)) begin
                  w_state_n   = DONE;
                  w_quarter_n = 1'b0;
                  w_coil_en_n = 1'b0;
               end
            end else begin
               w_div_n = r_div + DIV_W'(1);
            end
         end
         DONE: begin
            // Flag must be seen low once before another turn
            if (!bus.quarter_spin_started) begin
               w_state_n = IDLE;
               w_busy_n  = 1'b0;
            end
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
      unique case (w_phase_n)
         2'd0: w_coil_n = 4'b1100;
         2'd1: w_coil_n = 4'b0110;
         2'd2: w_coil_n = 4'b0011;
         2'd3: w_coil_n = 4'b1001;
         default: w_coil_n = 4'b1100;
      endcase
   end

   // State and registered outputs; reset dominates everything
   always_ff @(posedge clk) begin
      if (resetb) begin
         r_state      <= IDLE;
         r_div        <= '0;
         r_phase      <= 2'd0;
         r_dir        <= 1'b0;
         r_quarter    <= 1'b0;
         r_coil       <= 4'b1100;
         r_coil_en    <= 1'b0;
         r_step_pulse <= 1'b0;
         r_steps_done <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_div        <= w_div_n;
         r_phase      <= w_phase_n;
         r_dir        <= w_dir_n;
         r_quarter    <= w_quarter_n;
         r_coil       <= w_coil_n;
         r_coil_en    <= w_coil_en_n;
         r_step_pulse <= w_step_n;
         r_steps_done <= w_steps_n;
         r_busy       <= w_busy_n;
      end
   end

   assign bus.quarter    = r_quarter;
   assign bus.coil       = r_coil;
   assign bus.coil_en    = r_coil_en;
   assign bus.step_pulse = r_step_pulse;
   assign bus.steps_done = r_steps_done;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_quarter_step_driver.sv
// Bench for quarter_step_driver: turns with random direction, hold
// and abort points, checked against a closed-form turn model.
module tb_quarter_step_driver;

   localparam int SD   = 4;
   localparam int SPQ  = 3;
   localparam int CW   = 8;
   localparam int TURN = SD * SPQ;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   m_phase = 0;

   quarter_step_driver_if #(.CNT_W(CW)) bus ();

   quarter_step_driver #(
      .STEP_DIV(SD),
      .STEPS_PER_QUARTER(SPQ),
      .DIV_W(17),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .resetb(resetb),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] tbl(input int p);
      logic [3:0] t [4];
      t[0] = 4'b1100;
      t[1] = 4'b0110;
      t[2] = 4'b0011;
      t[3] = 4'b1001;
      return t[p];
   endfunction

   function automatic int ph(input int p, input bit d, input int k);
      return (((p + (d ? k : -k)) % 4) + 4) % 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_turn(input bit d, input int abort_at,
                           input int flip_at, input int hold);
      int p0;
      int k;
      bit eq;
      bit ep;
      p0 = m_phase;
      bus.dir = d;
      bus.abort = 1'b0;
      bus.quarter_spin_started = 1'b1;
      tick();
      checks++;
      if ({bus.quarter, bus.busy, bus.coil_en, bus.step_pulse}
          !== 4'b1110 || bus.steps_done !== CW'(0)
          || bus.coil !== tbl(p0)) begin
         errors++;
         $display("FAIL start: q/b/en/p=%b%b%b%b steps=%0d coil=%b exp 1110 0 %b",
                  bus.quarter, bus.busy, bus.coil_en, bus.step_pulse,
                  bus.steps_done, bus.coil, tbl(p0));
      end
      for (int c = 1; c <= TURN; c++) begin
         if (c == flip_at) bus.dir = ~d;
         if (c == abort_at) bus.abort = 1'b1;
         tick();
         if (c == abort_at) begin
            k = (c - 1) / SD;
            checks++;
            if ({bus.quarter, bus.busy, bus.coil_en, bus.step_pulse}
                !== 4'b0000 || bus.steps_done !== CW'(k)
                || bus.coil !== tbl(ph(p0, d, k))) begin
               errors++;
               $display("FAIL abort c=%0d: q/b/en/p=%b%b%b%b steps=%0d coil=%b exp 0000 %0d %b",
                        c, bus.quarter, bus.busy, bus.coil_en,
                        bus.step_pulse, bus.steps_done, bus.coil,
                        k, tbl(ph(p0, d, k)));
            end
            m_phase = ph(p0, d, k);
            bus.abort = 1'b0;
            bus.quarter_spin_started = 1'b0;
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.quarter !== 1'b0) begin
               errors++;
               $display("FAIL post_abort: busy=%b quarter=%b exp 0 0",
                        bus.busy, bus.quarter);
            end
            return;
         end
         k  = c / SD;
         ep = (c % SD == 0);
         eq = (c < TURN);
         checks++;
         if (bus.quarter !== eq || bus.coil_en !== eq
             || bus.busy !== 1'b1 || bus.step_pulse !== ep
             || bus.steps_done !== CW'(k)
             || bus.coil !== tbl(ph(p0, d, k))) begin
            errors++;
            $display("FAIL run c=%0d d=%0b: q=%b en=%b b=%b p=%b steps=%0d coil=%b exp q=%b p=%b steps=%0d coil=%b",
                     c, d, bus.quarter, bus.coil_en, bus.busy,
                     bus.step_pulse, bus.steps_done, bus.coil,
                     eq, ep, k, tbl(ph(p0, d, k)));
         end
      end
      m_phase = ph(p0, d, SPQ);
      for (int h = 0; h < hold; h++) begin
         tick();
         checks++;
         if (bus.quarter !== 1'b0 || bus.busy !== 1'b1
             || bus.step_pulse !== 1'b0
             || bus.steps_done !== CW'(SPQ)) begin
            errors++;
            $display("FAIL done_hold h=%0d: q=%b b=%b p=%b steps=%0d exp 0 1 0 %0d",
                     h, bus.quarter, bus.busy, bus.step_pulse,
                     bus.steps_done, SPQ);
         end
      end
      bus.quarter_spin_started = 1'b0;
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.quarter !== 1'b0
          || bus.steps_done !== CW'(SPQ)
          || bus.coil !== tbl(m_phase)) begin
         errors++;
         $display("FAIL done_exit: b=%b q=%b steps=%0d coil=%b exp 0 0 %0d %b",
                  bus.busy, bus.quarter, bus.steps_done, bus.coil,
                  SPQ, tbl(m_phase));
      end
   endtask

   task automatic test_reset();
      bus.quarter_spin_started = 1'b0;
      bus.dir = 1'b0;
      bus.abort = 1'b0;
      resetb = 1'b1;
      tick();
      tick();
      resetb = 1'b0;
      m_phase = 0;
      checks++;
      if ({bus.quarter, bus.coil_en, bus.step_pulse, bus.busy}
          !== 4'b0000 || bus.steps_done !== CW'(0)
          || bus.coil !== 4'b1100) begin
         errors++;
         $display("FAIL reset: q/en/p/b=%b%b%b%b steps=%0d coil=%b exp 0000 0 1100",
                  bus.quarter, bus.coil_en, bus.step_pulse, bus.busy,
                  bus.steps_done, bus.coil);
      end
   endtask

   task automatic test_forward();
      run_turn(1'b1, 0, 0, 0);
   endtask

   task automatic test_reverse_wrap();
      run_turn(1'b0, 0, 0, 0);
      run_turn(1'b0, 0, 0, 1);
   endtask

   task automatic test_done_hold();
      run_turn(1'b1, 0, 0, 5);
      run_turn(1'b1, 0, 0, 0);
   endtask

   task automatic test_abort();
      run_turn(1'b1, 2 * SD, 0, 0);
      bus.quarter_spin_started = 1'b1;
      bus.abort = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.quarter !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_abort: q=%b b=%b exp 0 0",
                  bus.quarter, bus.busy);
      end
      bus.quarter_spin_started = 1'b0;
      bus.abort = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run();
      bus.dir = 1'b1;
      bus.quarter_spin_started = 1'b1;
      tick();
      for (int c = 1; c <= SD + 1; c++) tick();
      resetb = 1'b1;
      tick();
      resetb = 1'b0;
      bus.quarter_spin_started = 1'b0;
      m_phase = 0;
      checks++;
      if ({bus.quarter, bus.coil_en, bus.step_pulse, bus.busy}
          !== 4'b0000 || bus.steps_done !== CW'(0)
          || bus.coil !== 4'b1100) begin
         errors++;
         $display("FAIL mid_reset: q/en/p/b=%b%b%b%b steps=%0d coil=%b exp 0000 0 1100",
                  bus.quarter, bus.coil_en, bus.step_pulse, bus.busy,
                  bus.steps_done, bus.coil);
      end
      for (int c = 0; c < 2 * SD; c++) begin
         tick();
         checks++;
         if (bus.step_pulse !== 1'b0 || bus.quarter !== 1'b0) begin
            errors++;
            $display("FAIL post_reset c=%0d: p=%b q=%b exp 0 0",
                     c, bus.step_pulse, bus.quarter);
         end
      end
   endtask

   task automatic test_dir_change();
      run_turn(1'b1, 0, SD + 1, 0);
      run_turn(1'b0, 0, SD + 2, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         bit d;
         int ab;
         d  = 1'($urandom % 2);
         ab = ($urandom % 3 == 0) ? int'($urandom_range(1, TURN)) : 0;
         run_turn(d, ab, int'($urandom_range(0, TURN)),
                  int'($urandom_range(0, 4)));
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse_wrap();
      test_done_hold();
      test_abort();
      test_reset_mid_run();
      test_dir_change();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
